hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS data_path. It keeps a shadow copy of the destination-register and write-control bits for each stage. From these it generates:
- load-use stalls, bubble insertion into ID/EX, and a global freeze while data memory is not ready;
- ALU-operand forwarding selects, plus a WB-to-ID bypass.
It sits beside data_path and the control unit, and drives the enables of the PC, IF/ID and the remaining pipeline registers.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, width of the saturating stall counter

Ports:
clock  in  1  single clock; all state updates on the falling edge, aligned with data_path pipeline registers
reset  in  1  synchronous, active-high
ifid_rs  in  REG_AW  rs field of the instruction in IF/ID
ifid_rt  in  REG_AW  rt field in IF/ID
ifid_rd  in  REG_AW  rd field in IF/ID
id_uses_rt  in  1  decoded instruction reads rt (R-type, sw)
id_regwrite  in  1  RegWrite from control for the ID instruction
id_memread  in  1  MemRead from control
id_memwrite  in  1  MemWrite from control
id_regdest  in  1  RegDest from control (1 = rd, 0 = rt)
dmem_ready  in  1  data memory has completed the EX/MEM access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
pipe_en  out  1  load enable for ID/EX, EX/MEM and MEM/WB
idex_bubble  out  1  load zeroed controls into ID/EX
fwd_a  out  2  ALU A select: 00 regfile, 01 MEM/WB result, 10 EX/MEM aluout
fwd_b  out  2  ALU B-register select, same encoding
wb_byp_a  out  1  ID read of rs takes the WB data
wb_byp_b  out  1  ID read of rt takes the WB data
hz_state  out  2  00 RUN, 01 LU_STALL, 10 MEM_WAIT
stall_cnt  out  CNT_W  saturating count of stall/freeze cycles

Behaviour:
- Reset (at a clock edge with reset=1): all shadow registers cleared (dest=0, regwrite=0, memread=0, memwrite=0); hz_state=RUN; stall_cnt=0. Resulting outputs: pc_write=1, ifid_write=1, pipe_en=1, idex_bubble=0, fwd=00, byp=0. A reset mid-stall or mid-freeze aborts it immediately.
- Shadow pipeline:
  - ID/EX slot holds rs, rt, dest = id_regdest ? ifid_rd : ifid_rt, plus regwrite, memread, memwrite.
  - EX/MEM and MEM/WB slots hold dest and regwrite; EX/MEM also holds memread and memwrite.
  - Slots advance only when pipe_en=1. When idex_bubble=1, the ID/EX control bits load as 0.
- Freeze, evaluated first: mem_busy = (ex_memread | ex_memwrite) & !dmem_ready. While mem_busy: pc_write=0, ifid_write=0, pipe_en=0, idex_bubble=0, and all state holds. Next hz_state=MEM_WAIT.
- Load-use, only when not mem_busy: lu = idex_memread & idex_dest!=0 & (idex_dest==ifid_rs | (id_uses_rt & idex_dest==ifid_rt)).
  - When lu: pc_write=0, ifid_write=0, pipe_en=1, idex_bubble=1. Next hz_state=LU_STALL.
  - The stall lasts exactly 1 cycle. Next cycle the load is in EX/MEM and forwarding resolves the dependency.
- Otherwise all enables are 1, bubble=0, and next hz_state=RUN.
- Forwarding (combinational from shadow state), per operand using idex_rs / idex_rt:
  - 10 if ex_regwrite & ex_dest!=0 & ex_dest==src;
  - else 01 if wb_regwrite & wb_dest!=0 & wb_dest==src;
  - else 00.
  - EX/MEM has priority. Register 0 is never forwarded.
- WB bypass: wb_byp_a = wb_regwrite & wb_dest!=0 & wb_dest==ifid_rs; wb_byp_b is the same against ifid_rt.
- A load whose value is needed at EX/MEM with the EX selector (10) is impossible by construction. The bench asserts this.
- stall_cnt increments on every cycle with pc_write=0 and saturates at all-ones.
- Latency: control outputs are combinational, valid in the same cycle. State updates after 1 clock.

Decomposition:
- Shared package/header (with constants.h): FWD_RF/FWD_WB/FWD_EX encodings and HZ_RUN/HZ_LU/HZ_MEM state codes.
- One natural sub-module, fwd_unit: purely combinational compare logic, instantiated once and producing fwd_a/fwd_b. Stall logic, FSM and shadow registers stay in hazard_ctrl.

Test Plan:
- Reset held 2 cycles, then released with no traffic -> pc_write=1, pipe_en=1, fwd_a=fwd_b=00, stall_cnt=0, hz_state=00.
- add $3,$1,$2 then sub $4,$3,$5 -> second instr in EX: fwd_a=10. Same but with one independent instr between -> fwd_a=01.
- lw $3,0($1) then add $4,$3,$3 -> exactly one cycle with pc_write=0 and idex_bubble=1, then fwd_a=fwd_b=01. stall_cnt=1.
- lw into $0 followed by a use of $0 -> no stall, fwd=00.
- sw in EX/MEM with dmem_ready low 3 cycles while a load-use hazard sits in ID -> 3 cycles pipe_en=0 and hz_state=10, then 1 LU stall. stall_cnt=4.
- Assert reset during MEM_WAIT -> the next cycle has all enables=1, shadow cleared, hz_state=00.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller state codes and the forwarding priority helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_EX = 2'b10;

    typedef enum logic [1:0] {
        HZ_RUN = 2'b00,
        HZ_LU  = 2'b01,
        HZ_MEM = 2'b10
    } hz_state_e;

    // The younger producer (EX/MEM) always shadows an older one in MEM/WB.
    function automatic logic [1:0] fwd_select(input logic ex_hit, input logic wb_hit);
        if (ex_hit) begin
            return FWD_EX;
        end
        if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational ALU-operand forwarding compare for the EX stage.
// Register 0 is hard-wired to zero and is never a forwarding source.
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_dest,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic ex_valid;
    logic wb_valid;
    logic ex_hit_a;
    logic ex_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;

    always_comb begin
        ex_valid = ex_regwrite & (ex_dest != '0);
        wb_valid = wb_regwrite & (wb_dest != '0);
        ex_hit_a = ex_valid & (ex_dest == idex_rs);
        ex_hit_b = ex_valid & (ex_dest == idex_rt);
        wb_hit_a = wb_valid & (wb_dest == idex_rs);
        wb_hit_b = wb_valid & (wb_dest == idex_rt);
        fwd_a    = fwd_select(ex_hit_a, wb_hit_a);
        fwd_b    = fwd_select(ex_hit_b, wb_hit_b);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: shadows the destination/write-control bits of
// each stage and derives stalls, bubbles, memory freeze, forwarding and WB bypass.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic [REG_AW-1:0] ifid_rd,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_regdest,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              pipe_en,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              wb_byp_a,
    output logic              wb_byp_b,
    output logic [1:0]        hz_state,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_AW-1:0] idex_rs_q,   idex_rs_d;
    logic [REG_AW-1:0] idex_rt_q,   idex_rt_d;
    logic [REG_AW-1:0] idex_dest_q, idex_dest_d;
    logic              idex_regwrite_q, idex_regwrite_d;
    logic              idex_memread_q,  idex_memread_d;
    logic              idex_memwrite_q, idex_memwrite_d;

    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;
    logic              ex_memwrite_q, ex_memwrite_d;

    logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
    logic              wb_regwrite_q, wb_regwrite_d;

    hz_state_e         hz_state_q, hz_state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [REG_AW-1:0] id_dest;
    logic              mem_busy;
    logic              lu_stall;

    assign id_dest = id_regdest ? ifid_rd : ifid_rt;

    // Memory freeze dominates; a load-use hazard is only acted on once memory is free.
    always_comb begin
        mem_busy    = (ex_memread_q | ex_memwrite_q) & ~dmem_ready;
        lu_stall    = idex_memread_q & (idex_dest_q != '0) &
                      ((idex_dest_q == ifid_rs) | (id_uses_rt & (idex_dest_q == ifid_rt)));
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pipe_en     = 1'b1;
        idex_bubble = 1'b0;
        hz_state_d  = HZ_RUN;
        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_en    = 1'b0;
            hz_state_d = HZ_MEM;
        end else if (lu_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            hz_state_d  = HZ_LU;
        end
    end

    // A bubble clears the whole ID/EX slot so it can never look like a forwarding consumer.
    always_comb begin
        idex_rs_d       = idex_rs_q;
        idex_rt_d       = idex_rt_q;
        idex_dest_d     = idex_dest_q;
        idex_regwrite_d = idex_regwrite_q;
        idex_memread_d  = idex_memread_q;
        idex_memwrite_d = idex_memwrite_q;
        ex_dest_d       = ex_dest_q;
        ex_regwrite_d   = ex_regwrite_q;
        ex_memread_d    = ex_memread_q;
        ex_memwrite_d   = ex_memwrite_q;
        wb_dest_d       = wb_dest_q;
        wb_regwrite_d   = wb_regwrite_q;
        if (pipe_en) begin
            wb_dest_d     = ex_dest_q;
            wb_regwrite_d = ex_regwrite_q;
            ex_dest_d     = idex_dest_q;
            ex_regwrite_d = idex_regwrite_q;
            ex_memread_d  = idex_memread_q;
            ex_memwrite_d = idex_memwrite_q;
            if (idex_bubble) begin
                idex_rs_d       = '0;
                idex_rt_d       = '0;
                idex_dest_d     = '0;
                idex_regwrite_d = 1'b0;
                idex_memread_d  = 1'b0;
                idex_memwrite_d = 1'b0;
            end else begin
                idex_rs_d       = ifid_rs;
                idex_rt_d       = ifid_rt;
                idex_dest_d     = id_dest;
                idex_regwrite_d = id_regwrite;
                idex_memread_d  = id_memread;
                idex_memwrite_d = id_memwrite;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Updates on the falling edge to line up with the data_path pipeline registers.
    always_ff @(negedge clock) begin
        if (reset) begin
            idex_rs_q       <= '0;
            idex_rt_q       <= '0;
            idex_dest_q     <= '0;
            idex_regwrite_q <= 1'b0;
            idex_memread_q  <= 1'b0;
            idex_memwrite_q <= 1'b0;
            ex_dest_q       <= '0;
            ex_regwrite_q   <= 1'b0;
            ex_memread_q    <= 1'b0;
            ex_memwrite_q   <= 1'b0;
            wb_dest_q       <= '0;
            wb_regwrite_q   <= 1'b0;
            hz_state_q      <= HZ_RUN;
            stall_cnt_q     <= '0;
        end else begin
            idex_rs_q       <= idex_rs_d;
            idex_rt_q       <= idex_rt_d;
            idex_dest_q     <= idex_dest_d;
            idex_regwrite_q <= idex_regwrite_d;
            idex_memread_q  <= idex_memread_d;
            idex_memwrite_q <= idex_memwrite_d;
            ex_dest_q       <= ex_dest_d;
            ex_regwrite_q   <= ex_regwrite_d;
            ex_memread_q    <= ex_memread_d;
            ex_memwrite_q   <= ex_memwrite_d;
            wb_dest_q       <= wb_dest_d;
            wb_regwrite_q   <= wb_regwrite_d;
            hz_state_q      <= hz_state_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    hazard_ctrl_fwd_unit #(
        .REG_AW(REG_AW)
    ) u_fwd_unit (
        .idex_rs     (idex_rs_q),
        .idex_rt     (idex_rt_q),
        .ex_regwrite (ex_regwrite_q),
        .ex_dest     (ex_dest_q),
        .wb_regwrite (wb_regwrite_q),
        .wb_dest     (wb_dest_q),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    assign wb_byp_a  = wb_regwrite_q & (wb_dest_q != '0) & (wb_dest_q == ifid_rs);
    assign wb_byp_b  = wb_regwrite_q & (wb_dest_q != '0) & (wb_dest_q == ifid_rt);
    assign hz_state  = hz_state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed instruction table, a stall-counter
// saturation run, and randomized traffic against a stage-array reference model.
module tb_hazard_ctrl;

    localparam int AW     = 5;
    localparam int CW     = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic [AW-1:0] ifid_rs, ifid_rt, ifid_rd;
    logic          id_uses_rt, id_regwrite, id_memread, id_memwrite, id_regdest;
    logic          dmem_ready;
    logic          pc_write, ifid_write, pipe_en, idex_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic          wb_byp_a, wb_byp_b;
    logic [1:0]    hz_state;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ifid_rd     (ifid_rd),
        .id_uses_rt  (id_uses_rt),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_memwrite (id_memwrite),
        .id_regdest  (id_regdest),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .pipe_en     (pipe_en),
        .idex_bubble (idex_bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .wb_byp_a    (wb_byp_a),
        .wb_byp_b    (wb_byp_b),
        .hz_state    (hz_state),
        .stall_cnt   (stall_cnt)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] rs, rt, rd;
        logic uses_rt, regwrite, memread, memwrite, regdest;
    } instr_t;

    typedef struct packed {
        logic [AW-1:0] rs, rt, dest;
        logic rw, mr, mw;
    } slot_t;

    typedef struct {
        logic   rst, ready, chk;
        instr_t ins;
        logic   pcw, pipe, bub;
        logic [1:0] fa, fb;
        logic   ba, bb;
        logic [1:0] hz;
        int     cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic instr_t i_nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t i_r(input int rs, input int rt, input int rd);
        instr_t i;
        i = '0;
        i.rs = AW'(rs); i.rt = AW'(rt); i.rd = AW'(rd);
        i.uses_rt = 1'b1; i.regwrite = 1'b1; i.regdest = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_lw(input int rs, input int rt);
        instr_t i;
        i = '0;
        i.rs = AW'(rs); i.rt = AW'(rt);
        i.regwrite = 1'b1; i.memread = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_sw(input int rs, input int rt);
        instr_t i;
        i = '0;
        i.rs = AW'(rs); i.rt = AW'(rt);
        i.uses_rt = 1'b1; i.memwrite = 1'b1;
        return i;
    endfunction

    function automatic vec_t mk(input logic rst, input logic ready, input instr_t ins,
                                input logic chk, input logic pcw, input logic pipe,
                                input logic bub, input logic [1:0] fa, input logic [1:0] fb,
                                input logic ba, input logic bb, input logic [1:0] hz,
                                input int cnt);
        vec_t v;
        v.rst = rst; v.ready = ready; v.ins = ins; v.chk = chk;
        v.pcw = pcw; v.pipe = pipe; v.bub = bub; v.fa = fa; v.fb = fb;
        v.ba = ba; v.bb = bb; v.hz = hz; v.cnt = cnt;
        return v;
    endfunction

    task automatic applyStimulus(input instr_t ins, input logic ready, input logic rst);
        reset       = rst;
        dmem_ready  = ready;
        ifid_rs     = ins.rs;
        ifid_rt     = ins.rt;
        ifid_rd     = ins.rd;
        id_uses_rt  = ins.uses_rt;
        id_regwrite = ins.regwrite;
        id_memread  = ins.memread;
        id_memwrite = ins.memwrite;
        id_regdest  = ins.regdest;
        #3;
    endtask

    task automatic advance();
        @(negedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input string tag, input logic pcw, input logic pipe,
                               input logic bub, input logic [1:0] fa, input logic [1:0] fb,
                               input logic ba, input logic bb, input logic [1:0] hz,
                               input int cnt);
        checkOutput({tag, ".pc_write"},    32'(pc_write),    32'(pcw));
        checkOutput({tag, ".ifid_write"},  32'(ifid_write),  32'(pcw));
        checkOutput({tag, ".pipe_en"},     32'(pipe_en),     32'(pipe));
        checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
        checkOutput({tag, ".fwd_a"},       32'(fwd_a),       32'(fa));
        checkOutput({tag, ".fwd_b"},       32'(fwd_b),       32'(fb));
        checkOutput({tag, ".wb_byp_a"},    32'(wb_byp_a),    32'(ba));
        checkOutput({tag, ".wb_byp_b"},    32'(wb_byp_b),    32'(bb));
        checkOutput({tag, ".hz_state"},    32'(hz_state),    32'(hz));
        checkOutput({tag, ".stall_cnt"},   32'(stall_cnt),   32'(cnt));
    endtask

    // Reference model: m_pipe[0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB.
    slot_t m_pipe[3];
    logic [1:0] m_hz;
    int m_cnt;

    function automatic slot_t slot_of(input instr_t ins);
        slot_t s;
        s.rs = ins.rs; s.rt = ins.rt;
        s.dest = ins.regdest ? ins.rd : ins.rt;
        s.rw = ins.regwrite; s.mr = ins.memread; s.mw = ins.memwrite;
        return s;
    endfunction

    function automatic logic writes(input slot_t s, input logic [AW-1:0] r);
        return s.rw && s.dest != 0 && s.dest == r;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
        if (writes(m_pipe[1], src)) return 2'b10;
        if (writes(m_pipe[2], src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_busy(input logic ready);
        return (m_pipe[1].mr || m_pipe[1].mw) && !ready;
    endfunction

    function automatic logic m_lu(input instr_t ins);
        slot_t ld;
        ld = m_pipe[0];
        return ld.mr && ld.dest != 0 &&
               (ld.dest == ins.rs || (ins.uses_rt && ld.dest == ins.rt));
    endfunction

    task automatic m_step(input instr_t ins, input logic rst, input logic busy, input logic lu);
        if (rst) begin
            for (int k = 0; k < 3; k++) m_pipe[k] = '0;
            m_hz  = 2'b00;
            m_cnt = 0;
        end else begin
            m_hz = busy ? 2'b10 : (lu ? 2'b01 : 2'b00);
            if ((busy || lu) && m_cnt < CNT_MAX) m_cnt++;
            if (!busy) begin
                m_pipe[2] = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = lu ? slot_t'('0) : slot_of(ins);
            end
        end
    endtask

    function automatic instr_t rand_instr();
        int kind;
        kind = int'($urandom_range(0, 3));
        case (kind)
            0:       return i_nop();
            1:       return i_r(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                int'($urandom_range(0, 3)));
            2:       return i_lw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            default: return i_sw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        endcase
    endfunction

    vec_t tbl[34];

    initial begin
        instr_t cur;
        logic hold, rst, ready, busy, lu;

        tbl[0]  = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[1]  = mk(0, 1, i_r(1, 2, 3),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[2]  = mk(0, 1, i_r(3, 5, 4),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[3]  = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd2, 2'd0, 0, 0, 2'd0, 0);
        tbl[4]  = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[5]  = mk(0, 1, i_r(1, 2, 3),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[6]  = mk(0, 1, i_r(7, 8, 6),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[7]  = mk(0, 1, i_r(3, 5, 4),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[8]  = mk(0, 1, i_r(3, 3, 9),  1, 1, 1, 0, 2'd1, 2'd0, 1, 1, 2'd0, 0);
        tbl[9]  = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[10] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[11] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[12] = mk(0, 1, i_lw(1, 3),    1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[13] = mk(0, 1, i_r(3, 3, 4),  1, 0, 1, 1, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[14] = mk(0, 1, i_r(3, 3, 4),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd1, 1);
        tbl[15] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd1, 2'd1, 0, 0, 2'd0, 1);
        tbl[16] = mk(0, 1, i_lw(1, 0),    1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[17] = mk(0, 1, i_r(0, 0, 5),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[18] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[19] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[20] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[21] = mk(0, 1, i_sw(1, 2),    1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[22] = mk(0, 1, i_lw(1, 7),    1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[23] = mk(0, 0, i_r(7, 7, 8),  1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1);
        tbl[24] = mk(0, 0, i_r(7, 7, 8),  1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd2, 2);
        tbl[25] = mk(0, 0, i_r(7, 7, 8),  1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd2, 3);
        tbl[26] = mk(0, 1, i_r(7, 7, 8),  1, 0, 1, 1, 2'd0, 2'd0, 0, 0, 2'd2, 4);
        tbl[27] = mk(0, 1, i_r(7, 7, 8),  1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd1, 5);
        tbl[28] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd1, 2'd1, 0, 0, 2'd0, 5);
        tbl[29] = mk(0, 1, i_sw(1, 2),    1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 5);
        tbl[30] = mk(0, 1, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 5);
        tbl[31] = mk(0, 0, i_r(1, 2, 9),  1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 5);
        tbl[32] = mk(1, 0, i_r(1, 2, 9),  0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
        tbl[33] = mk(0, 0, i_nop(),       1, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);

        // Reset held for two clocks.
        applyStimulus(i_nop(), 1'b1, 1'b1);
        advance();
        applyStimulus(i_nop(), 1'b1, 1'b1);
        advance();

        for (int n = 0; n < 34; n++) begin
            applyStimulus(tbl[n].ins, tbl[n].ready, tbl[n].rst);
            if (tbl[n].chk) begin
                checkVector($sformatf("row%0d", n), tbl[n].pcw, tbl[n].pipe, tbl[n].bub,
                            tbl[n].fa, tbl[n].fb, tbl[n].ba, tbl[n].bb, tbl[n].hz, tbl[n].cnt);
            end
            advance();
        end

        // Long memory freeze drives the stall counter into saturation.
        applyStimulus(i_sw(1, 2), 1'b1, 1'b0);
        advance();
        applyStimulus(i_nop(), 1'b1, 1'b0);
        advance();
        for (int n = 0; n < 35; n++) begin
            applyStimulus(i_nop(), 1'b0, 1'b0);
            if (n == 0) checkOutput("sat.freeze_pipe_en", 32'(pipe_en), 32'(0));
            advance();
        end
        applyStimulus(i_nop(), 1'b0, 1'b0);
        checkOutput("sat.stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        checkOutput("sat.hz_state", 32'(hz_state), 32'(2));
        advance();
        applyStimulus(i_nop(), 1'b1, 1'b0);
        checkOutput("sat.release_pc_write", 32'(pc_write), 32'(1));
        advance();
        applyStimulus(i_nop(), 1'b1, 1'b0);
        checkOutput("sat.hold_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        checkOutput("sat.run_hz_state", 32'(hz_state), 32'(0));
        advance();

        // Randomized traffic against the reference model.
        cur  = i_nop();
        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst   = (n == 0) || ($urandom_range(0, 79) == 0);
            ready = ($urandom_range(0, 3) != 0);
            if (!hold) cur = rand_instr();
            applyStimulus(cur, ready, rst);
            busy = m_busy(ready);
            lu   = !busy && m_lu(cur);
            if (!rst) begin
                checkVector($sformatf("rnd%0d", n), !(busy || lu), !busy, lu,
                            m_fwd(m_pipe[0].rs), m_fwd(m_pipe[0].rt),
                            writes(m_pipe[2], cur.rs), writes(m_pipe[2], cur.rt),
                            m_hz, m_cnt);
                checks++;
                if (fwd_a == 2'b10 && m_pipe[1].mr) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d.ex_load_fwd: got fwd_a=%0d with a load in EX/MEM, expected no EX forward of a load", n, fwd_a);
                end
            end
            hold = !rst && (busy || lu);
            m_step(cur, rst, busy, lu);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
